reg_bank_router: RTL and testbench
==================================

# reg_bank_router

Sequencer between the AXI-Lite slave's simple register user interface and up to NUM_BANKS independent register banks. Decodes the top SEL_WIDTH address bits into a bank, issues a one-cycle write or read strobe to that bank and waits for its acknowledge. It then returns a single response strobe with data and an error flag to the slave. Unacknowledged accesses are terminated by a timeout, and unmapped bank codes are rejected, so the AXI-Lite bus can never hang.

## Interface
- ADDR_WIDTH, 16, register address width (matches slave)
- DATA_WIDTH, 32, register data width
- NUM_BANKS, 4, number of attached banks (1..2^SEL_WIDTH)
- SEL_WIDTH, 4, address MSBs used as bank select; LOCAL_WIDTH = ADDR_WIDTH-SEL_WIDTH
- TIMEOUT_CYCLES, 64, max cycles waiting for a bank ack (>=2)

- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on clk rising edge)
- i_reg_in_rdy  in  1  write request level from slave, held until acked
- o_reg_in_ack_stb  out  1  one-cycle write completion strobe
- i_reg_address  in  ADDR_WIDTH  request address
- i_reg_in_data  in  DATA_WIDTH  write data
- i_reg_out_req  in  1  read request level from slave
- o_reg_out_rdy_stb  out  1  one-cycle read completion strobe
- o_reg_out_data  out  DATA_WIDTH  read data, valid with o_reg_out_rdy_stb
- o_reg_invalid_addr  out  1  error flag, valid with either completion strobe
- o_bank_wr_stb  out  NUM_BANKS  one-hot one-cycle write strobe
- o_bank_rd_stb  out  NUM_BANKS  one-hot one-cycle read strobe
- o_bank_addr  out  LOCAL_WIDTH  local offset (i_reg_address low bits), held until response
- o_bank_wdata  out  DATA_WIDTH  write data, held until response
- i_bank_ack  in  NUM_BANKS  per-bank completion
- i_bank_err  in  NUM_BANKS  per-bank error, sampled with ack
- i_bank_rdata  in  NUM_BANKS*DATA_WIDTH  bank k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- o_busy  out  1  high in any state except IDLE

## Operation
- All outputs are registered. On reset, every output is 0 and state is IDLE.
- States: IDLE, WAIT_ACK, RESPOND, RELEASE.
- IDLE: when i_reg_in_rdy is high (priority) or i_reg_out_req is high, latch the direction, sel = i_reg_address[ADDR_WIDTH-1 -: SEL_WIDTH], the offset and the write data.
  - If sel < NUM_BANKS: assert o_bank_wr_stb[sel] or o_bank_rd_stb[sel] for exactly one cycle, clear the timeout counter, and go to WAIT_ACK.
  - If sel >= NUM_BANKS: issue no bank strobe, set err=1 and data=0, and go to RESPOND.
- WAIT_ACK: the counter increments each cycle.
  - On i_bank_ack[sel]: capture i_bank_err[sel] and, for a read, the bank's rdata, then go to RESPOND.
  - If the counter reaches TIMEOUT_CYCLES-1 with no ack: set err=1 and data=0, then go to RESPOND.
  - Acks from non-selected banks are ignored.
- RESPOND: pulse o_reg_in_ack_stb (write) or o_reg_out_rdy_stb (read) for one cycle. o_reg_invalid_addr and o_reg_out_data are valid in the same cycle and hold until the next response. Go to RELEASE.
- RELEASE: wait until i_reg_in_rdy==0 and i_reg_out_req==0, then return to IDLE. The slave holds its read request level past the completion strobe, so RELEASE prevents double issue.
- Any i_bank_ack arriving in IDLE, RESPOND or RELEASE (e.g., a late ack after timeout) is ignored.
- Simultaneous write and read request in IDLE: the write is serviced; the read is not.
- Reset mid-operation: return immediately to IDLE with all outputs 0. A request still asserted after reset deasserts is treated as a new request.

## Timing
- Request sampled in IDLE at cycle 0 → bank strobe high during cycle 1 only.
- Ack seen in cycle n (n>=1, including during the strobe cycle) → completion strobe high during cycle n+1.
- Minimum latency from request to completion strobe: 2 cycles (ack in cycle 1).
- Invalid bank → completion strobe in cycle 1, with no bank strobe ever.
- Timeout → completion strobe in cycle TIMEOUT_CYCLES+1 with invalid=1.
- o_bank_addr and o_bank_wdata are stable from cycle 1 until the completion strobe.
- At most one bank strobe bit is high in any cycle. Bank strobes and completion strobes are never high together.

## Test plan
- Write 0xCAFE_0001 to address 0x1010, bank1 acks in cycle 1 → o_bank_wr_stb=0010 in cycle 1; o_bank_addr=0x010, wdata=0xCAFE_0001; o_reg_in_ack_stb in cycle 2; invalid=0.
- Read address 0x2004, bank2 acks 3 cycles after its strobe with rdata 0x1234_5678 and err=0 → o_reg_out_rdy_stb one cycle after the ack; data=0x1234_5678; invalid=0. Hold i_reg_out_req high 5 more cycles → no second o_bank_rd_stb.
- Read address 0x7000 (sel=7 >= NUM_BANKS) → no bank strobe; o_reg_out_rdy_stb in cycle 1 with invalid=1 and data=0.
- Write to bank0 with no ack, TIMEOUT_CYCLES=64 → o_reg_in_ack_stb in cycle 65 with invalid=1. A late bank0 ack in cycle 70 is ignored: no extra strobe, state unchanged.
- Bank3 read acked with err=1 while bank2 also asserts ack → only bank3's response is used; invalid=1.
- rst=0 asserted in WAIT_ACK cycle 3 → all outputs 0 the next cycle and o_busy=0. With the request held after rst=1, it is re-issued: a fresh bank strobe one cycle after reset deasserts.

Source files
------------

// File: rtl/reg_bank_router.sv
// rtl/reg_bank_router.sv - sequencer from the register user interface to NUM_BANKS register banks
module reg_bank_router #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_BANKS      = 4,
  parameter int SEL_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_reg_in_rdy,
  output logic                                 o_reg_in_ack_stb,
  input  logic [ADDR_WIDTH-1:0]                i_reg_address,
  input  logic [DATA_WIDTH-1:0]                i_reg_in_data,
  input  logic                                 i_reg_out_req,
  output logic                                 o_reg_out_rdy_stb,
  output logic [DATA_WIDTH-1:0]                o_reg_out_data,
  output logic                                 o_reg_invalid_addr,
  output logic [NUM_BANKS-1:0]                 o_bank_wr_stb,
  output logic [NUM_BANKS-1:0]                 o_bank_rd_stb,
  output logic [ADDR_WIDTH-SEL_WIDTH-1:0]      o_bank_addr,
  output logic [DATA_WIDTH-1:0]                o_bank_wdata,
  input  logic [NUM_BANKS-1:0]                 i_bank_ack,
  input  logic [NUM_BANKS-1:0]                 i_bank_err,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]      i_bank_rdata,
  output logic                                 o_busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, RESPOND, RELEASE} state_t;

  state_t                  state;
  logic                    is_write;
  logic [NUM_BANKS-1:0]    sel_mask;
  logic [CNT_W-1:0]        cnt;

  logic [SEL_WIDTH-1:0]    sel_in;
  logic [NUM_BANKS-1:0]    dec_mask;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    ack_hit;
  logic                    err_hit;

  assign sel_in  = i_reg_address[ADDR_WIDTH-1 -: SEL_WIDTH];
  assign ack_hit = |(i_bank_ack & sel_mask);
  assign err_hit = |(i_bank_err & sel_mask);

  // One-hot decode of the incoming bank code (all-zero for unmapped codes) and read-data mux of the latched bank
  always_comb begin
    dec_mask  = '0;
    sel_rdata = '0;
    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
      dec_mask[k] = (32'(sel_in) == k);
      if (sel_mask[k]) sel_rdata = i_bank_rdata[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Request sequencer: issue, wait for ack or timeout, respond once, then wait for the request to drop
  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= IDLE;
      is_write           <= 1'b0;
      sel_mask           <= '0;
      cnt                <= '0;
      o_reg_in_ack_stb   <= 1'b0;
      o_reg_out_rdy_stb  <= 1'b0;
      o_reg_out_data     <= '0;
      o_reg_invalid_addr <= 1'b0;
      o_bank_wr_stb      <= '0;
      o_bank_rd_stb      <= '0;
      o_bank_addr        <= '0;
      o_bank_wdata       <= '0;
      o_busy             <= 1'b0;
    end else begin
      o_bank_wr_stb     <= '0;
      o_bank_rd_stb     <= '0;
      o_reg_in_ack_stb  <= 1'b0;
      o_reg_out_rdy_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (i_reg_in_rdy || i_reg_out_req) begin
            is_write     <= i_reg_in_rdy;
            sel_mask     <= dec_mask;
            o_bank_addr  <= i_reg_address[ADDR_WIDTH-SEL_WIDTH-1:0];
            o_bank_wdata <= i_reg_in_data;
            cnt          <= '0;
            o_busy       <= 1'b1;
            if (|dec_mask) begin
              if (i_reg_in_rdy) o_bank_wr_stb <= dec_mask;
              else              o_bank_rd_stb <= dec_mask;
              state <= WAIT_ACK;
            end else begin
              // Unmapped bank: answer immediately with an error, no bank is touched
              o_reg_invalid_addr <= 1'b1;
              o_reg_out_data     <= '0;
              o_reg_in_ack_stb   <= i_reg_in_rdy;
              o_reg_out_rdy_stb  <= ~i_reg_in_rdy;
              state              <= RESPOND;
            end
          end
        end
        WAIT_ACK: begin
          cnt <= cnt + 1'b1;
          if (ack_hit) begin
            o_reg_invalid_addr <= err_hit;
            if (!is_write) o_reg_out_data <= sel_rdata;
            o_reg_in_ack_stb   <= is_write;
            o_reg_out_rdy_stb  <= ~is_write;
            state              <= RESPOND;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES-1)) begin
            o_reg_invalid_addr <= 1'b1;
            o_reg_out_data     <= '0;
            o_reg_in_ack_stb   <= is_write;
            o_reg_out_rdy_stb  <= ~is_write;
            state              <= RESPOND;
          end
        end
        RESPOND: begin
          state <= RELEASE;
        end
        RELEASE: begin
          if (!i_reg_in_rdy && !i_reg_out_req) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_router.sv
// tb/tb_reg_bank_router.sv - directed self-checking bench for reg_bank_router
module tb_reg_bank_router;

  logic          clk;
  logic          rst;
  logic          i_reg_in_rdy;
  logic          o_reg_in_ack_stb;
  logic [15:0]   i_reg_address;
  logic [31:0]   i_reg_in_data;
  logic          i_reg_out_req;
  logic          o_reg_out_rdy_stb;
  logic [31:0]   o_reg_out_data;
  logic          o_reg_invalid_addr;
  logic [3:0]    o_bank_wr_stb;
  logic [3:0]    o_bank_rd_stb;
  logic [11:0]   o_bank_addr;
  logic [31:0]   o_bank_wdata;
  logic [3:0]    i_bank_ack;
  logic [3:0]    i_bank_err;
  logic [127:0]  i_bank_rdata;
  logic          o_busy;

  int total;
  int bad;

  int          st_cnt, st_cyc, done_cyc, extra, overlap;
  logic [3:0]  st_wr, st_rd;
  logic [11:0] seen_addr, done_addr;
  logic [31:0] seen_wdata, done_data;
  logic        done_wr, done_rd, done_inv, busy_hold, busy_end;

  reg_bank_router dut (
    .clk                (clk),
    .rst                (rst),
    .i_reg_in_rdy       (i_reg_in_rdy),
    .o_reg_in_ack_stb   (o_reg_in_ack_stb),
    .i_reg_address      (i_reg_address),
    .i_reg_in_data      (i_reg_in_data),
    .i_reg_out_req      (i_reg_out_req),
    .o_reg_out_rdy_stb  (o_reg_out_rdy_stb),
    .o_reg_out_data     (o_reg_out_data),
    .o_reg_invalid_addr (o_reg_invalid_addr),
    .o_bank_wr_stb      (o_bank_wr_stb),
    .o_bank_rd_stb      (o_bank_rd_stb),
    .o_bank_addr        (o_bank_addr),
    .o_bank_wdata       (o_bank_wdata),
    .i_bank_ack         (i_bank_ack),
    .i_bank_err         (i_bank_err),
    .i_bank_rdata       (i_bank_rdata),
    .o_busy             (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts at a falling edge (cycle 0); cycle c is observed at the c-th following falling edge
  task automatic access(input logic wr, input logic rd, input logic [15:0] addr, input logic [31:0] wd,
                        input int ack_cyc, input int late_cyc, input logic [3:0] ack_bits,
                        input logic [3:0] err_bits, input logic [127:0] rd_all, input int hold);
    int c;
    st_cnt = 0; st_cyc = -1; st_wr = '0; st_rd = '0; done_cyc = -1; extra = 0; overlap = 0;
    done_wr = 1'b0; done_rd = 1'b0; done_inv = 1'b0; done_data = '0; seen_addr = '0; seen_wdata = '0;
    done_addr = '0;
    i_reg_in_rdy  = wr;
    i_reg_out_req = rd;
    i_reg_address = addr;
    i_reg_in_data = wd;
    i_bank_rdata  = rd_all;
    c = 0;
    while (c < 200 && (done_cyc < 0 || c < done_cyc + hold)) begin
      @(negedge clk);
      c++;
      if (|o_bank_wr_stb || |o_bank_rd_stb) begin
        if (done_cyc >= 0) extra++;
        else begin
          st_cnt++; st_cyc = c; st_wr = o_bank_wr_stb; st_rd = o_bank_rd_stb;
          seen_addr = o_bank_addr; seen_wdata = o_bank_wdata;
        end
        if (o_reg_in_ack_stb || o_reg_out_rdy_stb) overlap++;
      end
      if (o_reg_in_ack_stb || o_reg_out_rdy_stb) begin
        if (done_cyc >= 0) extra++;
        else begin
          done_cyc = c; done_wr = o_reg_in_ack_stb; done_rd = o_reg_out_rdy_stb;
          done_inv = o_reg_invalid_addr; done_data = o_reg_out_data; done_addr = o_bank_addr;
        end
      end
      if (c == ack_cyc || c == late_cyc) begin
        i_bank_ack = ack_bits; i_bank_err = err_bits;
      end else begin
        i_bank_ack = '0; i_bank_err = '0;
      end
    end
    i_bank_ack = '0;
    i_bank_err = '0;
    busy_hold = o_busy;
    i_reg_in_rdy  = 1'b0;
    i_reg_out_req = 1'b0;
    repeat (2) @(negedge clk);
    busy_end = o_busy;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0;
    i_reg_in_rdy = 1'b0; i_reg_out_req = 1'b0; i_reg_address = '0; i_reg_in_data = '0;
    i_bank_ack = '0; i_bank_err = '0; i_bank_rdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_strobes", {o_bank_wr_stb, o_bank_rd_stb, o_reg_in_ack_stb, o_reg_out_rdy_stb,
                             o_reg_invalid_addr, o_busy}, '0);
    check_eq("rst_data", {o_reg_out_data, o_bank_addr, o_bank_wdata}, '0);
    rst = 1'b1;
    @(negedge clk);

    // Write to bank1, acked in the strobe cycle
    access(1'b1, 1'b0, 16'h1010, 32'hCAFE_0001, 1, -1, 4'b0010, 4'b0000, '0, 0);
    check_eq("w1_stb_cnt", st_cnt, 1);
    check_eq("w1_stb_cyc", st_cyc, 1);
    check_eq("w1_wr_stb", {st_wr, st_rd}, {4'b0010, 4'b0000});
    check_eq("w1_addr", seen_addr, 12'h010);
    check_eq("w1_wdata", seen_wdata, 32'hCAFE_0001);
    check_eq("w1_done_cyc", done_cyc, 2);
    check_eq("w1_done_kind", {done_wr, done_rd, done_inv}, 3'b100);
    check_eq("w1_overlap", overlap, 0);
    check_eq("w1_busy_end", busy_end, 1'b0);

    // Read from bank2, ack three cycles after the strobe, request held 5 extra cycles
    access(1'b0, 1'b1, 16'h2004, 32'h0, 4, -1, 4'b0100, 4'b0000,
           {32'h0, 32'h1234_5678, 32'h0, 32'h0}, 5);
    check_eq("r2_rd_stb", {st_wr, st_rd, st_cyc[3:0]}, {4'b0000, 4'b0100, 4'd1});
    check_eq("r2_addr", seen_addr, 12'h004);
    check_eq("r2_done_cyc", done_cyc, 5);
    check_eq("r2_done_kind", {done_wr, done_rd, done_inv}, 3'b010);
    check_eq("r2_data", done_data, 32'h1234_5678);
    check_eq("r2_no_reissue", extra, 0);
    check_eq("r2_busy_end", busy_end, 1'b0);

    // Read from unmapped bank 7
    access(1'b0, 1'b1, 16'h7000, 32'h0, -1, -1, 4'b0000, 4'b0000, '0, 0);
    check_eq("r7_no_stb", st_cnt, 0);
    check_eq("r7_done_cyc", done_cyc, 1);
    check_eq("r7_done_kind", {done_wr, done_rd, done_inv}, 3'b011);
    check_eq("r7_data", done_data, 32'h0);

    // Write to bank0 with no ack: timeout, then a late ack in cycle 70
    access(1'b1, 1'b0, 16'h0008, 32'h0000_0055, -1, 70, 4'b0001, 4'b0000, '0, 10);
    check_eq("to_wr_stb", {st_wr, st_cyc[3:0]}, {4'b0001, 4'd1});
    check_eq("to_done_cyc", done_cyc, 65);
    check_eq("to_done_kind", {done_wr, done_rd, done_inv}, 3'b101);
    check_eq("to_data", done_data, 32'h0);
    check_eq("to_addr_held", done_addr, 12'h008);
    check_eq("to_late_ack", extra, 0);
    check_eq("to_busy_hold", busy_hold, 1'b1);
    check_eq("to_busy_end", busy_end, 1'b0);

    // Read from bank3 acked with error while bank2 also acks
    access(1'b0, 1'b1, 16'h3000, 32'h0, 2, -1, 4'b1100, 4'b1000,
           {32'hAAAA_5555, 32'h0BAD_0BAD, 32'h0, 32'h0}, 0);
    check_eq("r3_rd_stb", st_rd, 4'b1000);
    check_eq("r3_done_cyc", done_cyc, 3);
    check_eq("r3_done_kind", {done_wr, done_rd, done_inv}, 3'b011);
    check_eq("r3_data", done_data, 32'hAAAA_5555);

    // Read from bank1 while bank0 acks with an error that must be ignored
    access(1'b0, 1'b1, 16'h1000, 32'h0, 1, -1, 4'b0011, 4'b0001,
           {32'h0, 32'h0, 32'h8765_4321, 32'hFFFF_FFFF}, 0);
    check_eq("r1_done_cyc", done_cyc, 2);
    check_eq("r1_done_kind", {done_wr, done_rd, done_inv}, 3'b010);
    check_eq("r1_data", done_data, 32'h8765_4321);

    // Simultaneous write and read: the write wins
    access(1'b1, 1'b1, 16'h0020, 32'h0000_BEEF, 2, -1, 4'b0001, 4'b0000, '0, 0);
    check_eq("wr_prio_stb", {st_wr, st_rd}, {4'b0001, 4'b0000});
    check_eq("wr_prio_done", {done_cyc[3:0], done_wr, done_rd, done_inv}, {4'd3, 3'b100});
    check_eq("wr_prio_wdata", seen_wdata, 32'h0000_BEEF);

    // Write to unmapped bank 15
    access(1'b1, 1'b0, 16'hF000, 32'h1, -1, -1, 4'b0000, 4'b0000, '0, 0);
    check_eq("wF_done", {done_cyc[3:0], done_wr, done_rd, done_inv}, {4'd1, 3'b101});
    check_eq("wF_no_stb", st_cnt, 0);

    // Reset during WAIT_ACK, request held across reset gets re-issued
    i_reg_in_rdy  = 1'b1;
    i_reg_address = 16'h0ABC;
    i_reg_in_data = 32'h0000_0001;
    @(negedge clk);
    check_eq("rs_first_stb", o_bank_wr_stb, 4'b0001);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rs_outputs_zero", {o_bank_wr_stb, o_bank_rd_stb, o_reg_in_ack_stb, o_reg_out_rdy_stb,
                                 o_reg_invalid_addr, o_busy, o_reg_out_data, o_bank_addr, o_bank_wdata}, '0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rs_reissue", {o_bank_wr_stb, o_bank_addr, o_busy}, {4'b0001, 12'hABC, 1'b1});
    i_bank_ack = 4'b0001;
    @(negedge clk);
    check_eq("rs_done", {o_reg_in_ack_stb, o_reg_invalid_addr, o_bank_wr_stb}, {2'b10, 4'b0000});
    i_bank_ack   = '0;
    i_reg_in_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rs_idle", o_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
